// File: rtl/instruction_memory_port_if.sv
// rtl/instruction_memory_port_if.sv - fetch-side and backing-memory signals of the instruction port
interface instruction_memory_port_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] instruction_rd1;
  logic [DATA_WIDTH-1:0] instruction_rd1_out;
  logic                  instruction_valid;
  logic                  mem_req;
  logic [ADDR_WIDTH:0]   mem_addr;
  logic                  mem_ack;
  logic [7:0]            mem_rdata;

  // slave is the port itself; master is whoever drives fetch and models memory
  modport slave (
    input  instruction_rd1, mem_ack, mem_rdata,
    output instruction_rd1_out, instruction_valid, mem_req, mem_addr
  );
  modport master (
    output instruction_rd1, mem_ack, mem_rdata,
    input  instruction_rd1_out, instruction_valid, mem_req, mem_addr
  );
endinterface

// File: rtl/instruction_memory_port.sv
// rtl/instruction_memory_port.sv - two-byte instruction fetch responder with one-word buffer
module instruction_memory_port #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16
) (
  input logic                      clock,
  input logic                      reset_n,
  instruction_memory_port_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DRAIN} state_t;

  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic [ADDR_WIDTH-1:0] tag;
  logic                  tag_valid;
  logic [7:0]            lo;
  logic [DATA_WIDTH-1:0] word_q;
  logic                  mem_req_q;
  logic [ADDR_WIDTH:0]   mem_addr_q;

  logic hit, redirect, ack;
  logic start_fetch, take_lo, take_hi, drop;

  assign hit      = tag_valid && (bus.instruction_rd1 == tag);
  assign redirect = bus.instruction_rd1 != fetch_addr;
  // acks outside an outstanding request are meaningless and ignored
  assign ack      = bus.mem_ack && mem_req_q;

  assign bus.instruction_valid   = hit;
  assign bus.instruction_rd1_out = word_q;
  assign bus.mem_req             = mem_req_q;
  assign bus.mem_addr            = mem_addr_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    start_fetch = 1'b0;
    take_lo     = 1'b0;
    take_hi     = 1'b0;
    drop        = 1'b0;
    case (state)
      IDLE: begin
        if (!hit) begin
          start_fetch = 1'b1;
          next_state  = LOW;
        end
      end
      LOW: begin
        // a redirect that coincides with the low-byte ack has nothing left outstanding
        if (ack && redirect) begin
          drop       = 1'b1;
          next_state = IDLE;
        end else if (ack) begin
          take_lo    = 1'b1;
          next_state = HIGH;
        end else if (redirect) begin
          next_state = DRAIN;
        end
      end
      HIGH: begin
        if (ack) begin
          take_hi    = 1'b1;
          next_state = IDLE;
        end else if (redirect) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (ack) begin
          drop       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_addr <= '0;
      tag        <= '0;
      tag_valid  <= 1'b0;
      lo         <= '0;
      word_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      if (start_fetch) begin
        fetch_addr <= bus.instruction_rd1;
        tag_valid  <= 1'b0;
        mem_req_q  <= 1'b1;
        mem_addr_q <= {bus.instruction_rd1, 1'b0};
      end
      if (take_lo) begin
        lo         <= bus.mem_rdata;
        mem_addr_q <= {fetch_addr, 1'b1};
      end
      if (take_hi) begin
        word_q    <= {bus.mem_rdata, lo};
        tag       <= fetch_addr;
        tag_valid <= 1'b1;
        mem_req_q <= 1'b0;
      end
      if (drop) begin
        mem_req_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_instruction_memory_port.sv
// tb/tb_instruction_memory_port.sv - directed bench for instruction_memory_port
module tb_instruction_memory_port;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  instruction_memory_port_if #(.ADDR_WIDTH(20), .DATA_WIDTH(16)) bus ();

  instruction_memory_port #(.ADDR_WIDTH(20), .DATA_WIDTH(16)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory model: byte n reads as n[7:0]; ack after cur_delay idle request cycles
  int          delay_fixed = 0;
  int          cur_delay = 0;
  bit          rand_delay = 1'b0;
  bit          force_ack = 1'b0;
  int          cnt = 0;
  logic [20:0] hs_log[$];
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic        prev_rst = 1'b0;
  logic [20:0] prev_addr = '0;

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    forever begin
      @(posedge clock);
      #1;
      if (reset_n && prev_rst && prev_req && !prev_ack) begin
        check("req_held", {31'd0, bus.mem_req}, 32'd1);
        check("addr_stable", {11'd0, bus.mem_addr}, {11'd0, prev_addr});
      end
      bus.mem_ack = 1'b0;
      if (!reset_n || !bus.mem_req) begin
        cnt = 0;
      end else if (cnt >= cur_delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = bus.mem_addr[7:0];
        hs_log.push_back(bus.mem_addr);
        cnt = 0;
        cur_delay = rand_delay ? int'($urandom_range(0, 7)) : delay_fixed;
      end else begin
        cnt++;
      end
      if (force_ack && !bus.mem_req) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'hEE;
      end
      prev_req  = bus.mem_req;
      prev_ack  = bus.mem_ack;
      prev_addr = bus.mem_addr;
      prev_rst  = reset_n;
    end
  end

  task automatic set_delay(input int d);
    delay_fixed = d;
    cur_delay   = d;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.instruction_valid && n < 60);
    check({name, "_timeout"}, {31'd0, bus.instruction_valid}, 32'd1);
  endtask

  typedef struct {
    logic [19:0] addr;
    int          delay;
    logic [15:0] word;
    logic [20:0] b0;
    logic [20:0] b1;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int base;
    int n;
    int errs;
    logic [19:0] a;
    logic [20:0] b;

    vecs[0] = '{20'h00005, 0, 16'h0B0A, 21'h00000A, 21'h00000B};
    vecs[1] = '{20'hFFFFF, 0, 16'hFFFE, 21'h1FFFFE, 21'h1FFFFF};
    vecs[2] = '{20'h12345, 2, 16'h8B8A, 21'h02468A, 21'h02468B};
    vecs[3] = '{20'h00080, 5, 16'h0100, 21'h000100, 21'h000101};
    vecs[4] = '{20'h00003, 1, 16'h0706, 21'h000006, 21'h000007};

    // test 1: reset values, then fill of word 0 with zero-wait memory
    bus.instruction_rd1 = 20'h0;
    set_delay(0);
    repeat (2) @(negedge clock);
    check("rst_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_addr", {11'd0, bus.mem_addr}, 32'd0);
    check("rst_data", {16'd0, bus.instruction_rd1_out}, 32'd0);
    check("rst_valid", {31'd0, bus.instruction_valid}, 32'd0);
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock);
      if (i == 2) check("t1_valid_early", {31'd0, bus.instruction_valid}, 32'd0);
    end
    check("t1_valid_cyc3", {31'd0, bus.instruction_valid}, 32'd1);
    check("t1_data", {16'd0, bus.instruction_rd1_out}, 32'h0100);
    check("t1_hs_count", hs_log.size(), 32'd2);
    if (hs_log.size() >= 2) begin
      check("t1_b0", {11'd0, hs_log[0]}, 32'h0);
      check("t1_b1", {11'd0, hs_log[1]}, 32'h1);
    end

    // table-driven fills
    foreach (vecs[k]) begin
      set_delay(vecs[k].delay);
      base = hs_log.size();
      bus.instruction_rd1 = vecs[k].addr;
      wait_valid($sformatf("vec%0d", k));
      check($sformatf("vec%0d_data", k), {16'd0, bus.instruction_rd1_out}, {16'd0, vecs[k].word});
      check($sformatf("vec%0d_hs", k), hs_log.size() - base, 32'd2);
      if (hs_log.size() >= base + 2) begin
        check($sformatf("vec%0d_b0", k), {11'd0, hs_log[base]}, {11'd0, vecs[k].b0});
        check($sformatf("vec%0d_b1", k), {11'd0, hs_log[base+1]}, {11'd0, vecs[k].b1});
      end
    end

    // test 2: address 5 held for 10 cycles after fill
    set_delay(0);
    base = hs_log.size();
    bus.instruction_rd1 = 20'h5;
    wait_valid("t2");
    check("t2_fill_hs", hs_log.size() - base, 32'd2);
    base = hs_log.size();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.instruction_valid) n++;
    end
    check("t2_valid_held", n, 32'd10);
    check("t2_no_traffic", hs_log.size() - base, 32'd0);
    check("t2_data", {16'd0, bus.instruction_rd1_out}, 32'h0B0A);

    // test 3: redirect 5 -> 6 while the low byte is pending
    bus.instruction_rd1 = 20'h10;
    wait_valid("t3_pre");
    set_delay(3);
    base = hs_log.size();
    bus.instruction_rd1 = 20'h5;
    @(negedge clock);
    check("t3_req_up", {31'd0, bus.mem_req}, 32'd1);
    bus.instruction_rd1 = 20'h6;
    n = 0;
    errs = 0;
    while (hs_log.size() == base && n < 20) begin
      if (bus.mem_addr !== 21'h00A) errs++;
      @(negedge clock);
      n++;
    end
    check("t3_addr_hold", errs, 32'd0);
    wait_valid("t3");
    check("t3_data", {16'd0, bus.instruction_rd1_out}, 32'h0D0C);
    check("t3_hs", hs_log.size() - base, 32'd3);
    if (hs_log.size() >= base + 3) begin
      check("t3_drained", {11'd0, hs_log[base]}, 32'h00A);
      check("t3_b0", {11'd0, hs_log[base+1]}, 32'h00C);
      check("t3_b1", {11'd0, hs_log[base+2]}, 32'h00D);
    end

    // test 5: stray acks while idle, then reset while in HIGH
    base = hs_log.size();
    force_ack = 1'b1;
    errs = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (bus.mem_req !== 1'b0) errs++;
    end
    force_ack = 1'b0;
    check("t5_stray_req", errs, 32'd0);
    check("t5_stray_valid", {31'd0, bus.instruction_valid}, 32'd1);
    check("t5_stray_data", {16'd0, bus.instruction_rd1_out}, 32'h0D0C);
    set_delay(2);
    bus.instruction_rd1 = 20'h7;
    n = 0;
    while (hs_log.size() == base && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("t5_lo_ack", hs_log.size() - base, 32'd1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("t5_rst_req", {31'd0, bus.mem_req}, 32'd0);
    check("t5_rst_addr", {11'd0, bus.mem_addr}, 32'd0);
    check("t5_rst_data", {16'd0, bus.instruction_rd1_out}, 32'd0);
    check("t5_rst_valid", {31'd0, bus.instruction_valid}, 32'd0);
    repeat (2) @(negedge clock);
    base = hs_log.size();
    reset_n = 1'b1;
    wait_valid("t5_refetch");
    check("t5_data", {16'd0, bus.instruction_rd1_out}, 32'h0F0E);
    check("t5_hs", hs_log.size() - base, 32'd2);
    if (hs_log.size() >= base + 2) begin
      check("t5_b0", {11'd0, hs_log[base]}, 32'h00E);
      check("t5_b1", {11'd0, hs_log[base+1]}, 32'h00F);
    end

    // test 6: sequential stream with random ack delays
    rand_delay = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = 20'h200 + 20'(i);
      b = {a, 1'b0};
      base = hs_log.size();
      bus.instruction_rd1 = a;
      wait_valid($sformatf("t6_%0d", i));
      check($sformatf("t6_%0d_data", i), {16'd0, bus.instruction_rd1_out},
            {16'd0, b[7:0] | 8'h01, b[7:0]});
      check($sformatf("t6_%0d_hs", i), hs_log.size() - base, 32'd2);
      if (hs_log.size() >= base + 2) begin
        check($sformatf("t6_%0d_b0", i), {11'd0, hs_log[base]}, {11'd0, b});
        check($sformatf("t6_%0d_b1", i), {11'd0, hs_log[base+1]}, {11'd0, b | 21'd1});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
